// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_pkg
//   Types and default widths shared by the register-file write arbiter,
//   its bus interface and its round-robin sub-module.
//   Contents:
//     RF_DATA_WIDTH / RF_REG_NUM_WIDTH / RF_REG_FILE_SIZE  default sizes
//     DataPath, RegNumPath                                 datapath types
//     ArbStatePath                                         arbiter FSM states
//     RegWriteReq                                          one write request
// ---------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

  localparam int RF_DATA_WIDTH    = 32;
  localparam int RF_REG_NUM_WIDTH = 5;
  localparam int RF_REG_FILE_SIZE = 32;

  typedef logic [RF_DATA_WIDTH-1:0]    DataPath;
  typedef logic [RF_REG_NUM_WIDTH-1:0] RegNumPath;

  // ARB_INIT: zero sweep of registers 1..REG_FILE_SIZE-1
  // ARB_RUN : normal round-robin arbitration, terminal until reset
  typedef enum logic {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } ArbStatePath;

  typedef struct packed {
    logic      valid;
    RegNumPath num;
    DataPath   data;
  } RegWriteReq;

endpackage : regfile_write_arbiter_pkg

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bus between the writeback producers, the arbiter and the register file
//   write port.
//   Signals:
//     hold      1 = grant nothing this cycle
//     reqValid  per-requester write request
//     reqReady  one-hot grant (valid && ready completes the handshake)
//     reqData   per-requester write data
//     reqNum    per-requester destination register
//     wrData / wrNum / wrEnable   registered register-file write port
//   Modports:
//     master  producer / register-file side (drives requests)
//     slave   arbiter side (drives grants and the write port)
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5
);

  logic                     hold;
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ-1:0]       reqReady;
  logic [DATA_WIDTH-1:0]    reqData [NUM_REQ];
  logic [REG_NUM_WIDTH-1:0] reqNum  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    wrData;
  logic [REG_NUM_WIDTH-1:0] wrNum;
  logic                     wrEnable;

  modport master (
    output hold,
    output reqValid,
    input  reqReady,
    output reqData,
    output reqNum,
    input  wrData,
    input  wrNum,
    input  wrEnable
  );

  modport slave (
    input  hold,
    input  reqValid,
    output reqReady,
    input  reqData,
    input  reqNum,
    output wrData,
    output wrNum,
    output wrEnable
  );

endinterface : regfile_write_arbiter_if

// File: rtl/regfile_write_arbiter_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
//   Purely combinational round-robin picker. Starting at ptr and wrapping
//   upward, the first asserted request wins. The caller owns the pointer.
//   Ports:
//     req         in   NUM_REQ   request vector
//     ptr         in   IDX_W     highest-priority index this cycle
//     grant       out  NUM_REQ   one-hot grant (all 0 when no request)
//     grant_idx   out  IDX_W     index of the granted request
//     grant_valid out  1         1 when some request was granted
// ---------------------------------------------------------------------------
module round_robin_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule : round_robin_arbiter

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the register file's single write port between NUM_REQ result
//   producers with round-robin arbitration. The write port is driven from a
//   registered stage, so a write lands one cycle after its grant.
//   Optional feature (macro REGFILE_WRITE_ARBITER_INIT_SWEEP_EN): after reset
//   an INIT state writes zero to registers 1..REG_FILE_SIZE-1, since register
//   storage itself has no reset. Without the macro, reset goes straight to
//   RUN and no sweep counter exists.
//   Ports:
//     clk       in   1        clock, rising edge
//     rst_n     in   1        synchronous active-low reset
//     bus       slave modport of regfile_write_arbiter_if (requests + write port)
//     initDone  out  1        1 while in RUN
//     grantIdx  out  IDX_W    index of the last accepted requester
// ---------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int REG_NUM_WIDTH = RF_REG_NUM_WIDTH,
  parameter int REG_FILE_SIZE = RF_REG_FILE_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  regfile_write_arbiter_if.slave     bus,
  output logic                       initDone,
  output logic [$clog2(NUM_REQ)-1:0] grantIdx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("regfile_write_arbiter: NUM_REQ must be 2..8");
  end
  if (REG_FILE_SIZE < 2 || REG_FILE_SIZE > (1 << REG_NUM_WIDTH)) begin : g_bad_rf_size
    $error("regfile_write_arbiter: REG_FILE_SIZE does not fit REG_NUM_WIDTH");
  end

  ArbStatePath              state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic                     wr_en_q, wr_en_d;
  logic [REG_NUM_WIDTH-1:0] wr_num_q, wr_num_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [IDX_W-1:0]         grant_idx_q, grant_idx_d;

`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
  logic [REG_NUM_WIDTH-1:0] cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0] rr_grant;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic               init_done;

  round_robin_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (bus.reqValid),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_en_d     = 1'b0;
    wr_num_d    = wr_num_q;
    wr_data_d   = wr_data_q;
    grant_idx_d = grant_idx_q;
    req_ready   = '0;
    init_done   = 1'b0;
`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ARB_INIT: begin
`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
        wr_en_d   = 1'b1;
        wr_num_d  = cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + 1'b1;
        // The last sweep write is presented during the first RUN cycle,
        // which is why a RUN grant that same cycle never collides with it.
        if (cnt_q == REG_NUM_WIDTH'(REG_FILE_SIZE - 1)) begin
          state_d = ARB_RUN;
        end
`else
        state_d = ARB_RUN;
`endif
      end

      ARB_RUN: begin
        init_done = 1'b1;
        if (!bus.hold && rr_valid) begin
          req_ready   = rr_grant;
          wr_num_d    = bus.reqNum[rr_idx];
          wr_data_d   = bus.reqData[rr_idx];
          grant_idx_d = rr_idx;
          // Register 0 is hard-wired zero: accept the handshake but drop
          // the write itself.
          wr_en_d     = (bus.reqNum[rr_idx] != '0);
          ptr_d       = (rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
        end
      end

      default: begin
        state_d = ARB_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
      state_q <= ARB_INIT;
      cnt_q   <= REG_NUM_WIDTH'(1);
`else
      state_q <= ARB_RUN;
`endif
      ptr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_num_q    <= '0;
      wr_data_q   <= '0;
      grant_idx_q <= '0;
    end else begin
`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
      cnt_q <= cnt_d;
`endif
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_num_q    <= wr_num_d;
      wr_data_q   <= wr_data_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign bus.reqReady = req_ready;
  assign bus.wrEnable = wr_en_q;
  assign bus.wrNum    = wr_num_q;
  assign bus.wrData   = wr_data_q;
  assign initDone     = init_done;
  assign grantIdx     = grant_idx_q;

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int NREQ = 3;

  logic       clk;
  logic       rst_n;
  logic       init_done;
  logic [1:0] grant_idx;

  int n_vec;
  int n_fail;

  regfile_write_arbiter_if #(
    .NUM_REQ       (NREQ),
    .DATA_WIDTH    (32),
    .REG_NUM_WIDTH (5)
  ) bus ();

  regfile_write_arbiter #(
    .NUM_REQ       (NREQ),
    .DATA_WIDTH    (32),
    .REG_NUM_WIDTH (5),
    .REG_FILE_SIZE (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .initDone (init_done),
    .grantIdx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hold;
    logic [2:0]  valid;
    logic [4:0]  n0, n1, n2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  ready;
    logic        en;
    logic [4:0]  num;
    logic [31:0] data;
    logic [1:0]  gidx;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic hold, logic [2:0] valid,
                              logic [4:0] n0, logic [4:0] n1, logic [4:0] n2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic [2:0] ready, logic en, logic [4:0] num,
                              logic [31:0] data, logic [1:0] gidx);
    vec_t v;
    v.hold = hold; v.valid = valid;
    v.n0 = n0; v.n1 = n1; v.n2 = n2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.ready = ready; v.en = en; v.num = num; v.data = data; v.gidx = gidx;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.hold       = v.hold;
    bus.reqValid   = v.valid;
    bus.reqNum[0]  = v.n0;
    bus.reqNum[1]  = v.n1;
    bus.reqNum[2]  = v.n2;
    bus.reqData[0] = v.d0;
    bus.reqData[1] = v.d1;
    bus.reqData[2] = v.d2;
  endtask

  // Apply inputs mid-cycle, check the combinational grant before the edge,
  // then the registered write port after it.
  task automatic apply_vec(input int i, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("v%0d reqReady", i), 64'(bus.reqReady), 64'(v.ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d wrEnable", i), 64'(bus.wrEnable), 64'(v.en));
    check($sformatf("v%0d wrNum", i),    64'(bus.wrNum),    64'(v.num));
    check($sformatf("v%0d wrData", i),   64'(bus.wrData),   64'(v.data));
    check($sformatf("v%0d grantIdx", i), 64'(grant_idx),    64'(v.gidx));
    $display("vec %0d: hold=%0b valid=%03b ready=%03b wrEn=%0b wrNum=%0d wrData=%08h gidx=%0d",
             i, v.hold, v.valid, bus.reqReady, bus.wrEnable, bus.wrNum, bus.wrData, grant_idx);
  endtask

  initial begin
    vec_t z;
    n_vec  = 0;
    n_fail = 0;

    // Requesters 0/1/2 use reg 5/6/7 with data A0/A1/A2 unless noted.
    // Pointer after each vector shown on the right.
    vecs[0]  = mk(0, 3'b100, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'hDEADBEEF, 3'b100, 1, 5'd3, 32'hDEADBEEF, 2'd2); // ptr 0
    vecs[1]  = mk(0, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1, 5'd5, 32'hA0, 2'd0); // ptr 1
    vecs[2]  = mk(0, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1, 5'd6, 32'hA1, 2'd1); // ptr 2
    vecs[3]  = mk(0, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1, 5'd7, 32'hA2, 2'd2); // ptr 0
    vecs[4]  = mk(0, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1, 5'd5, 32'hA0, 2'd0); // ptr 1
    vecs[5]  = mk(1, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b000, 0, 5'd5, 32'hA0, 2'd0); // hold
    vecs[6]  = mk(1, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b000, 0, 5'd5, 32'hA0, 2'd0);
    vecs[7]  = mk(1, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b000, 0, 5'd5, 32'hA0, 2'd0);
    vecs[8]  = mk(1, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b000, 0, 5'd5, 32'hA0, 2'd0);
    vecs[9]  = mk(0, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1, 5'd6, 32'hA1, 2'd1); // ptr 2
    vecs[10] = mk(0, 3'b000, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b000, 0, 5'd6, 32'hA1, 2'd1); // idle
    vecs[11] = mk(0, 3'b001, 5'd0, 5'd6, 5'd7, 32'h55, 32'hA1, 32'hA2, 3'b001, 0, 5'd0, 32'h55, 2'd0); // reg 0, ptr 1
    vecs[12] = mk(0, 3'b111, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1, 5'd6, 32'hA1, 2'd1); // ptr 2
    vecs[13] = mk(0, 3'b011, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1, 5'd5, 32'hA0, 2'd0); // wrap, ptr 1
    vecs[14] = mk(0, 3'b011, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1, 5'd6, 32'hA1, 2'd1); // ptr 2
    vecs[15] = mk(0, 3'b100, 5'd5, 5'd6, 5'd7, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1, 5'd7, 32'hA2, 2'd2); // ptr 0

    z = mk(0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 5'd0, 32'h0, 2'd0);
    drive(z);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset wrEnable", 64'(bus.wrEnable), 64'(0));
    check("reset wrNum",    64'(bus.wrNum),    64'(0));
    check("reset wrData",   64'(bus.wrData),   64'(0));
    check("reset grantIdx", 64'(grant_idx),    64'(0));
    $display("reset: wrEn=%0b wrNum=%0d wrData=%08h gidx=%0d initDone=%0b",
             bus.wrEnable, bus.wrNum, bus.wrData, grant_idx, init_done);

`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
    check("reset initDone", 64'(init_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.reqValid = 3'b111;
    #1;
    check("init reqReady", 64'(bus.reqReady), 64'(0));
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sweep%0d wrEnable", k), 64'(bus.wrEnable), 64'(1));
      check($sformatf("sweep%0d wrNum", k),    64'(bus.wrNum),    64'(k));
      check($sformatf("sweep%0d wrData", k),   64'(bus.wrData),   64'(0));
      check($sformatf("sweep%0d initDone", k), 64'(init_done),    64'(k == 31));
      if (k < 31) check($sformatf("sweep%0d reqReady", k), 64'(bus.reqReady), 64'(0));
      $display("sweep %0d: wrEn=%0b wrNum=%0d initDone=%0b", k, bus.wrEnable, bus.wrNum, init_done);
    end
`else
    check("reset initDone", 64'(init_done), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("run initDone", 64'(init_done), 64'(1));
`endif

    for (int i = 0; i < 16; i++) begin
      apply_vec(i, vecs[i]);
    end

`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
    // Reset in the middle of the sweep restarts it at register 1.
    drive(z);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("mid wrNum before reset", 64'(bus.wrNum), 64'(9));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid reset wrEnable", 64'(bus.wrEnable), 64'(0));
    check("mid reset wrNum",    64'(bus.wrNum),    64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("restart%0d wrEnable", k), 64'(bus.wrEnable), 64'(1));
      check($sformatf("restart%0d wrNum", k),    64'(bus.wrNum),    64'(k));
      check($sformatf("restart%0d initDone", k), 64'(init_done),    64'(0));
      $display("restart %0d: wrEn=%0b wrNum=%0d", k, bus.wrEnable, bus.wrNum);
    end
`else
    // Without the sweep, a grant is possible in the first cycle after reset.
    @(negedge clk);
    rst_n = 1'b0;
    drive(z);
    @(posedge clk);
    #1;
    check("rerun reset wrEnable", 64'(bus.wrEnable), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.reqValid   = 3'b010;
    bus.reqNum[1]  = 5'd9;
    bus.reqData[1] = 32'h12345678;
    #1;
    check("first cycle initDone", 64'(init_done),    64'(1));
    check("first cycle reqReady", 64'(bus.reqReady), 64'(3'b010));
    @(posedge clk);
    #1;
    check("first grant wrEnable", 64'(bus.wrEnable), 64'(1));
    check("first grant wrNum",    64'(bus.wrNum),    64'(9));
    check("first grant wrData",   64'(bus.wrData),   64'(32'h12345678));
    check("first grant grantIdx", 64'(grant_idx),    64'(1));
    $display("first grant: wrEn=%0b wrNum=%0d wrData=%08h gidx=%0d",
             bus.wrEnable, bus.wrNum, bus.wrData, grant_idx);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_regfile_write_arbiter
